// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - PS/2 line inputs and decoded key/byte outputs bundle
interface ps2_keyboard_rx_if;
    logic       PS2Clk;
    logic       PS2Data;
    logic [7:0] KeyPress;
    logic       KeyRelease;
    logic       extended;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    modport master (
        input  PS2Clk, PS2Data,
        output KeyPress, KeyRelease, extended, rx_valid, rx_byte, frame_err
    );

    modport slave (
        output PS2Clk, PS2Data,
        input  KeyPress, KeyRelease, extended, rx_valid, rx_byte, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decode
module ps2_keyboard_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst,
    ps2_keyboard_rx_if.master bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state, next_state;
    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FW-1:0]  filt_cnt;
    logic           filt_clk, filt_clk_d;
    logic           fe;
    logic [TW-1:0]  tmo_cnt;
    logic           timeout;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic           parity_bit;
    logic           frame_good, frame_bad;
    logic           brk_flag, ext_flag;

    assign fe      = filt_clk_d & ~filt_clk;
    assign timeout = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT));

    // Synchronisers and the glitch filter on the clock line
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            clk_s1     <= bus.PS2Clk;
            clk_s2     <= clk_s1;
            dat_s1     <= bus.PS2Data;
            dat_s2     <= dat_s1;
            filt_clk_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt <= '0;
                filt_clk <= clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (fe) begin
            case (state)
                IDLE:    if (!dat_s2) next_state = DATA;
                DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP: begin
                    next_state = IDLE;
                    if (dat_s2 && (^{shift, parity_bit})) frame_good = 1'b1;
                    else                                  frame_bad  = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end else if (timeout) begin
            next_state = IDLE;
            frame_bad  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE || fe || timeout) tmo_cnt <= '0;
            else                                tmo_cnt <= tmo_cnt + 1'b1;
            if (fe) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  parity_bit <= dat_s2;
                    default: ;
                endcase
            end
        end
    end

    // Prefix decode; key outputs land in the same cycle as rx_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.KeyPress   <= 8'h00;
            bus.KeyRelease <= 1'b0;
            bus.extended   <= 1'b0;
            bus.rx_valid   <= 1'b0;
            bus.rx_byte    <= 8'h00;
            bus.frame_err  <= 1'b0;
            brk_flag       <= 1'b0;
            ext_flag       <= 1'b0;
        end else begin
            bus.rx_valid   <= frame_good;
            bus.frame_err  <= frame_bad;
            bus.KeyRelease <= 1'b0;
            if (frame_good) begin
                bus.rx_byte <= shift;
                if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    bus.KeyPress   <= shift;
                    bus.extended   <= ext_flag;
                    bus.KeyRelease <= brk_flag;
                    brk_flag       <= 1'b0;
                    ext_flag       <= 1'b0;
                end
            end else if (frame_bad) begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - scoreboard bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 20;

    typedef struct {
        logic       err;
        logic [7:0] data;
        logic [7:0] key;
        logic       ext;
        logic       rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    ps2_keyboard_rx_if bus ();

    ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    logic [7:0] m_key = 8'h00;
    logic       m_extout = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_good(input logic [7:0] d);
        exp_t e;
        logic rel;
        rel = 1'b0;
        if (d == 8'hE0) m_ext = 1'b1;
        else if (d == 8'hF0) m_brk = 1'b1;
        else begin
            m_key = d; m_extout = m_ext; rel = m_brk;
            m_brk = 1'b0; m_ext = 1'b0;
        end
        e.err = 1'b0; e.data = d; e.key = m_key; e.ext = m_extout; e.rel = rel;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        m_brk = 1'b0; m_ext = 1'b0;
        e.err = 1'b1; e.data = 8'h00; e.key = m_key; e.ext = m_extout; e.rel = 1'b0;
        q.push_back(e);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.PS2Data = bits[i];
            repeat (HALF) @(posedge clk);
            bus.PS2Clk = 1'b0;
            repeat (HALF) @(posedge clk);
            bus.PS2Clk = 1'b1;
        end
        bus.PS2Data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        if (bad_par || bad_stop) push_err();
        else                     push_good(d);
        send_bits({~bad_stop, par, d, 1'b0}, 11);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 1000; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        repeat (50) @(posedge clk);
        check(tag, q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_KeyPress", bus.KeyPress, 8'h00);
        check("rst_KeyRelease", bus.KeyRelease, 0);
        check("rst_extended", bus.extended, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_byte", bus.rx_byte, 8'h00);
        check("rst_frame_err", bus.frame_err, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.KeyRelease && !bus.rx_valid) begin
                check("stray_KeyRelease", bus.KeyRelease, 0);
            end else if (bus.rx_valid || bus.frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_event", {bus.rx_valid, bus.frame_err}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("frame_err", bus.frame_err, e.err);
                    check("rx_valid", bus.rx_valid, !e.err);
                    if (!e.err) check("rx_byte", bus.rx_byte, e.data);
                    check("KeyPress", bus.KeyPress, e.key);
                    check("extended", bus.extended, e.ext);
                    check("KeyRelease", bus.KeyRelease, e.rel);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.PS2Clk = 1'b1;
        bus.PS2Data = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_reset_outputs();
        @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        send_byte(8'h1C, 0, 0);
        drain("make");

        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        drain("break");

        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h75, 0, 0);
        send_byte(8'h29, 0, 0);
        drain("ext_break");

        send_byte(8'h1C, 1, 0);
        drain("parity_err");
        send_byte(8'h1C, 0, 1);
        drain("stop_err");

        push_err();
        send_bits(11'b000_0001_1100 << 0, 5);
        repeat (TIMEOUT + 10) @(posedge clk);
        drain("timeout");
        send_byte(8'h29, 0, 0);
        drain("after_timeout");

        bus.PS2Clk = 1'b0;
        repeat (FILTER_LEN - 2) @(posedge clk);
        bus.PS2Clk = 1'b1;
        repeat (50) @(posedge clk);
        send_byte(8'h1C, 0, 0);
        drain("glitch");

        send_byte(8'hF0, 0, 0);
        drain("pre_reset_break");
        send_bits(11'b000_0011_1000, 6);
        rst = 1'b1;
        m_brk = 1'b0; m_ext = 1'b0; m_key = 8'h00; m_extout = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_reset_outputs();
        @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        send_byte(8'h1C, 0, 0);
        drain("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
